// File: rtl/xc_malu_sched.sv
// Round-robin scheduler/sequencer that shares one multi-cycle MALU between the
// core execute stage (port A) and the crypto coprocessor (port B).
module xc_malu_sched #(
  parameter int          TIMEOUT    = 128,
  parameter bit          MASK_FLUSH = 1'b1,
  parameter logic [31:0] LFSR_SEED  = 32'h6A09E667
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        a_req_valid,
  input  logic        b_req_valid,
  output logic        a_req_ready,
  output logic        b_req_ready,
  input  logic [31:0] a_rs1,
  input  logic [31:0] a_rs2,
  input  logic [31:0] a_rs3,
  input  logic [31:0] b_rs1,
  input  logic [31:0] b_rs2,
  input  logic [31:0] b_rs3,
  input  logic [13:0] a_uop,
  input  logic [13:0] b_uop,
  input  logic [4:0]  a_pw,
  input  logic [4:0]  b_pw,
  input  logic        a_kill,
  input  logic        b_kill,
  output logic        a_rsp_valid,
  output logic        b_rsp_valid,
  input  logic        a_rsp_ready,
  input  logic        b_rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_err,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic [13:0] malu_uop,
  output logic [4:0]  malu_pw,
  output logic        malu_valid,
  output logic        malu_flush,
  output logic [31:0] malu_flush_data,
  input  logic [63:0] malu_result,
  input  logic        malu_ready
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_RESP} state_t;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic [13:0] uop;
    logic [4:0]  pw;
  } op_t;

  state_t          state, state_nx;
  op_t             op_q, req_op;
  logic            owner_q;   // 0 = A, 1 = B
  logic            last_q;    // last granted port, same encoding
  logic [WDW-1:0]  wdog_q;
  logic            flush_q, flush_nx;
  logic [31:0]     lfsr_q;

  logic a_elig, b_elig, grant_a, grant_b, grant, uop_ok;
  logic owner_kill, owner_rsp_ready, timeout;

  assign a_elig  = a_req_valid & ~a_kill;
  assign b_elig  = b_req_valid & ~b_kill;
  assign grant_a = (state == S_IDLE) & a_elig & (~b_elig | last_q);
  assign grant_b = (state == S_IDLE) & b_elig & (~a_elig | ~last_q);
  assign grant   = grant_a | grant_b;

  assign req_op = grant_b ? {b_rs1, b_rs2, b_rs3, b_uop, b_pw}
                          : {a_rs1, a_rs2, a_rs3, a_uop, a_pw};
  assign uop_ok = (req_op.uop != '0) && ((req_op.uop & (req_op.uop - 14'd1)) == '0);

  assign owner_kill      = owner_q ? b_kill      : a_kill;
  assign owner_rsp_ready = owner_q ? b_rsp_ready : a_rsp_ready;
  assign timeout         = (wdog_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    flush_nx = 1'b0;
    case (state)
      S_IDLE:  if (grant) state_nx = uop_ok ? S_BUSY : S_RESP;
      S_BUSY: begin
        // kill wins over a same-cycle result; either way the MALU needs a flush
        if (owner_kill)                  state_nx = S_DRAIN;
        else if (malu_ready || timeout)  state_nx = S_RESP;
        flush_nx = owner_kill | malu_ready | timeout;
      end
      S_DRAIN: state_nx = S_IDLE;
      S_RESP:  if (owner_kill || owner_rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_q       <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      wdog_q     <= '0;
      flush_q    <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      // Galois LFSR, polynomial x^32 + x^22 + x^2 + x + 1
      lfsr_q  <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
      flush_q <= flush_nx;
      if (grant) begin
        op_q    <= req_op;
        owner_q <= grant_b;
        last_q  <= grant_b;
        wdog_q  <= '0;
        if (!uop_ok) begin
          rsp_err    <= 1'b1;
          rsp_result <= '0;
        end
      end
      if (state == S_BUSY) begin
        wdog_q <= wdog_q + WDW'(1);
        if (!owner_kill) begin
          if (malu_ready) begin
            rsp_result <= malu_result;
            rsp_err    <= 1'b0;
          end else if (timeout) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end
        end
      end
    end
  end

  assign a_req_ready     = grant_a;
  assign b_req_ready     = grant_b;
  assign malu_valid      = (state == S_BUSY);
  assign malu_uop        = malu_valid ? op_q.uop : '0;
  assign malu_rs1        = op_q.rs1;
  assign malu_rs2        = op_q.rs2;
  assign malu_rs3        = op_q.rs3;
  assign malu_pw         = op_q.pw;
  assign malu_flush      = flush_q;
  assign malu_flush_data = MASK_FLUSH ? lfsr_q : 32'h0;
  assign a_rsp_valid     = (state == S_RESP) & ~owner_q;
  assign b_rsp_valid     = (state == S_RESP) &  owner_q;

endmodule

// File: tb/tb_xc_malu_sched.sv
// Directed bench for xc_malu_sched; the bench itself plays the MALU.
module tb_xc_malu_sched;

  logic        clock, resetn;
  logic        a_req_valid, b_req_valid, a_req_ready, b_req_ready;
  logic [31:0] a_rs1, a_rs2, a_rs3, b_rs1, b_rs2, b_rs3;
  logic [13:0] a_uop, b_uop;
  logic [4:0]  a_pw, b_pw;
  logic        a_kill, b_kill;
  logic        a_rsp_valid, b_rsp_valid, a_rsp_ready, b_rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_err;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic        malu_valid, malu_flush;
  logic [31:0] malu_flush_data;
  logic [63:0] malu_result;
  logic        malu_ready;

  int tests = 0;
  int fails = 0;

  xc_malu_sched dut (
    .clock(clock), .resetn(resetn),
    .a_req_valid(a_req_valid), .b_req_valid(b_req_valid),
    .a_req_ready(a_req_ready), .b_req_ready(b_req_ready),
    .a_rs1(a_rs1), .a_rs2(a_rs2), .a_rs3(a_rs3),
    .b_rs1(b_rs1), .b_rs2(b_rs2), .b_rs3(b_rs3),
    .a_uop(a_uop), .b_uop(b_uop), .a_pw(a_pw), .b_pw(b_pw),
    .a_kill(a_kill), .b_kill(b_kill),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid),
    .a_rsp_ready(a_rsp_ready), .b_rsp_ready(b_rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_uop(malu_uop), .malu_pw(malu_pw), .malu_valid(malu_valid),
    .malu_flush(malu_flush), .malu_flush_data(malu_flush_data),
    .malu_result(malu_result), .malu_ready(malu_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1ns after the active edge
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    a_req_valid = 0; b_req_valid = 0; a_kill = 0; b_kill = 0;
    a_rsp_ready = 0; b_rsp_ready = 0; malu_ready = 0; malu_result = '0;
    a_rs1 = 0; a_rs2 = 0; a_rs3 = 0; b_rs1 = 0; b_rs2 = 0; b_rs3 = 0;
    a_uop = 0; b_uop = 0; a_pw = 0; b_pw = 0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_malu_valid", malu_valid, 0);
    chk("rst_flush", malu_flush, 0);
    chk("rst_rsp", {a_rsp_valid, b_rsp_valid, rsp_err}, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flush_data", malu_flush_data, 32'h6A09E667);
    resetn = 1'b1;
    cyc();
    chk("lfsr_step1", malu_flush_data, 32'hB524F330);

    // A alone: mul 7*6
    a_req_valid = 1; a_uop = 14'h0010; a_rs1 = 7; a_rs2 = 6; a_rs3 = 3; a_pw = 5'b00001;
    #1;
    chk("mul_grant", {a_req_ready, b_req_ready}, 2'b10);
    cyc();
    a_req_valid = 0;
    chk("mul_busy_valid", malu_valid, 1);
    chk("mul_busy_ops", {malu_uop, malu_rs1, malu_rs2, malu_rs3, malu_pw},
        {14'h0010, 32'd7, 32'd6, 32'd3, 5'b00001});
    cyc();
    chk("mul_busy_hold", {malu_valid, malu_uop}, {1'b1, 14'h0010});
    malu_ready = 1; malu_result = 64'd42;
    cyc();
    malu_ready = 0; malu_result = '0;
    chk("mul_rsp", {a_rsp_valid, b_rsp_valid, rsp_err}, 3'b100);
    chk("mul_result", rsp_result, 64'd42);
    chk("mul_flush", {malu_flush, malu_valid, malu_uop}, {1'b1, 1'b0, 14'h0});
    chk("mul_ops_held", malu_rs1, 7);
    cyc();
    chk("mul_flush_once", malu_flush, 0);
    chk("mul_rsp_hold", {a_rsp_valid, rsp_result}, {1'b1, 64'd42});
    a_rsp_ready = 1;
    cyc();
    a_rsp_ready = 0;
    chk("mul_idle", {a_rsp_valid, malu_valid}, 2'b00);

    // both requesting from reset: A first, then B
    resetn = 0; #1; resetn = 1;
    a_req_valid = 1; a_uop = 14'h0010; a_rs1 = 3; a_rs2 = 5;
    b_req_valid = 1; b_uop = 14'h0020; b_rs1 = 9; b_rs2 = 9;
    #1;
    chk("tie1_grant", {a_req_ready, b_req_ready}, 2'b10);
    cyc();
    a_req_valid = 0;
    chk("tie1_busy", {malu_uop, malu_rs1}, {14'h0010, 32'd3});
    chk("tie1_b_wait", b_req_ready, 0);
    malu_ready = 1; malu_result = 64'd15;
    cyc();
    malu_ready = 0;
    chk("tie1_rsp", {a_rsp_valid, rsp_result}, {1'b1, 64'd15});
    chk("tie1_b_wait_rsp", b_req_ready, 0);
    a_rsp_ready = 1;
    cyc();
    a_rsp_ready = 0;
    #1;
    chk("tie2_grant_b", {a_req_ready, b_req_ready}, 2'b01);
    cyc();
    b_req_valid = 0;
    chk("tie2_busy", {malu_uop, malu_rs1}, {14'h0020, 32'd9});
    malu_ready = 1; malu_result = 64'd81;
    cyc();
    malu_ready = 0;
    chk("tie2_rsp", {a_rsp_valid, b_rsp_valid, rsp_result}, {2'b01, 64'd81});
    b_rsp_ready = 1;
    cyc();
    b_rsp_ready = 0;

    // third tie goes back to A; B waits while A's response is stalled
    a_req_valid = 1; a_uop = 14'h0010; a_rs1 = 1; a_rs2 = 1;
    b_req_valid = 1; b_uop = 14'h0002; b_rs1 = 100; b_rs2 = 7;
    #1;
    chk("tie3_grant_a", {a_req_ready, b_req_ready}, 2'b10);
    cyc();
    a_req_valid = 0;
    malu_ready = 1; malu_result = 64'hDEADBEEF_12345678;
    cyc();
    malu_ready = 0; malu_result = '0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_b_blocked", b_req_ready, 0);
      chk("stall_result", {a_rsp_valid, rsp_err, rsp_result}, {2'b10, 64'hDEADBEEF_12345678});
      cyc();
    end
    a_rsp_ready = 1;
    cyc();
    a_rsp_ready = 0;
    #1;
    chk("stall_b_grant", b_req_ready, 1);

    // B divu killed in its 5th BUSY cycle, with a same-cycle malu_ready
    cyc();
    b_req_valid = 0;
    chk("kill_busy", {malu_valid, malu_uop, malu_rs1}, {1'b1, 14'h0002, 32'd100});
    cyc();
    a_kill = 1;
    cyc();
    chk("kill_nonowner", {malu_valid, malu_flush}, 2'b10);
    a_kill = 0;
    cyc();
    cyc();
    b_kill = 1; malu_ready = 1; malu_result = 64'd14;
    cyc();
    b_kill = 0; malu_ready = 0; malu_result = '0;
    chk("kill_drain", {malu_flush, malu_valid, b_rsp_valid}, 3'b100);
    cyc();
    chk("kill_idle", {malu_flush, malu_valid, b_rsp_valid, a_rsp_valid}, 4'b0000);

    // illegal multi-hot uop
    a_req_valid = 1; a_uop = 14'h0003;
    #1;
    chk("ill_grant", a_req_ready, 1);
    cyc();
    a_req_valid = 0;
    chk("ill_rsp", {a_rsp_valid, rsp_err, rsp_result}, {2'b11, 64'd0});
    chk("ill_no_malu", {malu_valid, malu_flush}, 2'b00);
    a_rsp_ready = 1;
    cyc();
    a_rsp_ready = 0;
    chk("ill_idle", {a_rsp_valid, malu_valid, malu_flush}, 3'b000);

    // watchdog: MALU never answers
    a_req_valid = 1; a_uop = 14'h0010; a_rs1 = 2; a_rs2 = 2;
    cyc();
    a_req_valid = 0;
    n = 0;
    while (malu_valid && n < 300) begin
      n++;
      cyc();
    end
    chk("wd_busy_cycles", n, 128);
    chk("wd_rsp", {a_rsp_valid, rsp_err, rsp_result}, {2'b11, 64'd0});
    chk("wd_flush", malu_flush, 1);
    cyc();
    chk("wd_flush_once", malu_flush, 0);
    a_rsp_ready = 1;
    cyc();
    a_rsp_ready = 0;

    // kill in RESP drops the response; reset mid-operation
    a_req_valid = 1; a_uop = 14'h0001;
    cyc();
    a_req_valid = 0; malu_ready = 1; malu_result = 64'd5;
    cyc();
    malu_ready = 0; a_kill = 1;
    chk("rk_rsp", a_rsp_valid, 1);
    cyc();
    a_kill = 0;
    chk("rk_dropped", a_rsp_valid, 0);
    a_req_valid = 1; a_uop = 14'h0010;
    cyc();
    a_req_valid = 0;
    chk("rst_mid_busy", malu_valid, 1);
    resetn = 0; #1;
    chk("rst_mid_vals", {malu_valid, malu_flush, rsp_result, malu_flush_data},
        {2'b00, 64'd0, 32'h6A09E667});
    resetn = 1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xc_malu_sched.md
Name: xc_malu_sched

Overview:
- Two-requester scheduler and sequencer for the shared multi-cycle arithmetic unit (MALU).
- Port A is the core execute stage; port B is the crypto coprocessor issue path.
- Arbitrates round-robin, latches and holds operands and uop stable for the MALU's whole operation, captures its 64-bit result, and returns it to the owning requester.
- Issues the one-cycle MALU flush needed after every operation, since the MALU stays in its DONE state until flushed; also handles requester kills and a hang watchdog.

Parameters:
- TIMEOUT, 128: max cycles in BUSY before watchdog abort.
- MASK_FLUSH, 1: 1 = malu_flush_data driven from LFSR; 0 = zeros.
- LFSR_SEED, 32'h6A09E667: LFSR reset value (must be nonzero).

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- a_req_valid, b_req_valid  in  1  request present
- a_req_ready, b_req_ready  out  1  request accepted (grant) this cycle
- a_rs1, a_rs2, a_rs3, b_rs1, b_rs2, b_rs3  in  32 each  operands
- a_uop, b_uop  in  14  one-hot uop: [0]div [1]divu [2]rem [3]remu [4]mul [5]mulu [6]mulsu [7]clmul [8]pmul [9]pclmul [10]madd [11]msub [12]macc [13]mmul
- a_pw, b_pw  in  5  pack width {pw_2,pw_4,pw_8,pw_16,pw_32}
- a_kill, b_kill  in  1  requester pipeline flush; cancels that port's request/operation
- a_rsp_valid, b_rsp_valid  out  1  response valid to owner
- a_rsp_ready, b_rsp_ready  in  1  response accepted
- rsp_result  out  64  captured result (shared)
- rsp_err  out  1  1 = illegal uop or watchdog timeout
- malu_rs1, malu_rs2, malu_rs3  out  32 each  held operands
- malu_uop  out  14  held uop, zero when not BUSY
- malu_pw  out  5  held pack width
- malu_valid  out  1  MALU inputs valid
- malu_flush  out  1  MALU flush pulse
- malu_flush_data  out  32  flush fill data
- malu_result  in  64  MALU result
- malu_ready  in  1  MALU result ready

Behaviour:
- Async reset values:
  - state IDLE; last_grant = B, so A wins the first tie.
  - All outputs 0, except malu_flush_data = MASK_FLUSH ? LFSR_SEED : 0.
  - Watchdog counter 0.
- States: IDLE, BUSY, DRAIN, RESP.
- IDLE:
  - Eligible port: x_req_valid && !x_kill.
  - With one eligible port, grant it. With both eligible, grant the port that is not last_grant.
  - Grant actions: x_req_ready = 1 combinationally; latch rs1/rs2/rs3/uop/pw and owner; update last_grant.
  - Granted uop is one-hot: go to BUSY.
  - Granted uop is zero or multi-hot: rsp_err = 1, rsp_result = 0, go to RESP; no MALU activity.
- BUSY:
  - malu_valid = 1; latched values held on malu_*; watchdog increments each cycle.
  - malu_ready = 1: capture malu_result into rsp_result, set rsp_err = 0, go to RESP.
  - Owner kill: go to DRAIN, no response. Kill has priority over a same-cycle malu_ready.
  - Watchdog reaches TIMEOUT: rsp_err = 1, rsp_result = 0, go to RESP.
- DRAIN:
  - One cycle: malu_flush = 1, malu_valid = 0, then go to IDLE.
- RESP:
  - malu_valid = 0; owner's rsp_valid = 1 and held until owner rsp_ready.
  - malu_flush is registered and high exactly in the first RESP cycle; it is not asserted on the illegal-uop path.
  - rsp_valid && rsp_ready: go to IDLE. The earliest next grant is the following cycle, so there are no back-to-back grants in the same cycle.
  - Owner kill in RESP: drop the response (no handshake) and go to IDLE.
- Watchdog clears on every entry to BUSY.
- Kill on the non-owner port affects only that port's pending request, never the active operation.
- rsp_result and rsp_err stay stable throughout RESP. malu_* operands hold their last values outside BUSY; only malu_uop/malu_valid are zeroed.
- LFSR:
  - 32-bit Galois, taps 32,22,2,1; advances every cycle.
  - malu_flush_data = LFSR when MASK_FLUSH = 1, else 0.
- Latency:
  - Grant in cycle g; malu_valid is high from g+1.
  - If malu_ready is seen in cycle r, rsp_valid is high from r+1.
- Reset asserted mid-operation: immediate return to reset values. No flush pulse is issued; the MALU is reset by the same resetn.

Test Plan:
- A only, uop mul (bit4), rs1 = 7, rs2 = 6 -> a_req_ready in g; malu_valid held until malu_ready; a_rsp_valid with rsp_result = 42; malu_flush high one cycle; back in IDLE.
- A and B both valid from reset -> A granted first; A completes; B granted next; third simultaneous request -> A granted again (alternation).
- B divu 100/7 in progress, b_kill at cycle 5 of BUSY -> DRAIN, one malu_flush pulse, b_rsp_valid never asserted, IDLE next cycle.
- A uop = 14'h0003 (multi-hot) -> grant, a_rsp_valid with rsp_err = 1, rsp_result = 0, malu_valid never asserted.
- Stub MALU never raises malu_ready -> after 128 BUSY cycles a_rsp_valid with rsp_err = 1; malu_flush pulses once.
- a_rsp_ready held low 10 cycles -> rsp_result stable, b request not granted until A handshake completes.
